// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: default PCs, instruction width,
// opcode constants and the {pc, word} queue entry type.
package fetch_unit_pkg;

  localparam int          INST_W       = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_LIMIT_DEF = 32'h0000_03FC;

  localparam logic [6:0] OPC_ITYPE = 7'b0010011;
  localparam logic [6:0] OPC_RTYPE = 7'b0110011;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;

  typedef struct packed {
    logic [31:0]       pc;
    logic [INST_W-1:0] word;
  } fetch_entry_t;

  // Sequential successor of a fetch address; wraps to 0 after the limit.
  function automatic logic [31:0] next_pc(input logic [31:0] pc, input logic [31:0] limit);
    return (pc == limit) ? 32'h0 : pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bundles the ROM port, the decode valid/ready handshake and the redirect
// input of the fetch stage; master is the fetch side.
interface fetch_unit_if;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output imem_en, imem_addr, inst_valid, inst_data, inst_pc,
    input  imem_rdata, inst_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_en, imem_addr, inst_valid, inst_data, inst_pc,
    output imem_rdata, inst_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_queue.sv
// DEPTH-entry synchronous FIFO of {pc, word} entries; flush beats push.
// The caller guarantees no push when full and no pop when empty.
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic [CW-1:0] count,
  output fetch_entry_t head
);

  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // NOTE: storage has no reset; only the pointers and count do, and the
  // consumer masks the head while the queue is empty.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle-latency ROM and
// queues returned words for decode. Optional counters under FETCH_STATS_EN.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] PC_LIMIT = PC_LIMIT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  fetch_unit_if.master bus
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] stat_stall_cnt,
  output logic [31:0] stat_redirect_cnt
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   pc_d;
  logic          inflight;
  logic [CW-1:0] count;
  fetch_entry_t  head;
  fetch_entry_t  resp;
  logic          valid;
  logic          deq;
  logic          issue;
  logic          push;
  logic [CW:0]   occ;
  logic [31:0]   target;

  // NOTE: combinational signals use blocking assignments with every output
  // defaulted first, so no latches are inferred.
  always_comb begin
    valid  = (count != '0);
    deq    = valid & bus.inst_ready;
    // occupancy after this edge if nothing new were issued
    occ    = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(deq);
    issue  = rst_n & ~bus.redirect_valid & (occ < (CW+1)'(DEPTH));
    push   = inflight & ~bus.redirect_valid;
    target = bus.redirect_pc & 32'hFFFF_FFFC;
    resp   = '{pc: pc_d, word: bus.imem_rdata};
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      pc_d     <= '0;
      inflight <= 1'b0;
    end else if (bus.redirect_valid) begin
      fetch_pc <= target;
      inflight <= 1'b0;
    end else if (issue) begin
      fetch_pc <= next_pc(fetch_pc, PC_LIMIT);
      pc_d     <= fetch_pc;
      inflight <= 1'b1;
    end else begin
      inflight <= 1'b0;
    end
  end

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (deq),
    .flush (bus.redirect_valid),
    .din   (resp),
    .count (count),
    .head  (head)
  );

  assign bus.imem_en    = issue;
  assign bus.imem_addr  = fetch_pc;
  assign bus.inst_valid = valid;
  assign bus.inst_data  = valid ? head.word : '0;
  assign bus.inst_pc    = valid ? head.pc   : '0;

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_stall_cnt    <= '0;
      stat_redirect_cnt <= '0;
    end else begin
      if (!valid && stat_stall_cnt != 32'hFFFF_FFFF)
        stat_stall_cnt <= stat_stall_cnt + 32'd1;
      if (bus.redirect_valid && stat_redirect_cnt != 32'hFFFF_FFFF)
        stat_redirect_cnt <= stat_redirect_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a default instance plus a PC_LIMIT=0x0C
// instance, each fed by a ROM model whose word equals its address.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  fetch_unit_if ifa ();
  fetch_unit_if ifb ();

`ifdef FETCH_STATS_EN
  logic [31:0] stall_a, redir_a, stall_b, redir_b;
`endif

  fetch_unit dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
`ifdef FETCH_STATS_EN
    ,
    .stat_stall_cnt    (stall_a),
    .stat_redirect_cnt (redir_a)
`endif
  );

  fetch_unit #(.PC_LIMIT(32'h0000_000C)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
`ifdef FETCH_STATS_EN
    ,
    .stat_stall_cnt    (stall_b),
    .stat_redirect_cnt (redir_b)
`endif
  );

  logic [31:0] rom_a, rom_b;
  always_ff @(posedge clk) begin
    if (ifa.imem_en) rom_a <= ifa.imem_addr;
    if (ifb.imem_en) rom_b <= ifb.imem_addr;
  end
  assign ifa.imem_rdata = rom_a;
  assign ifb.imem_rdata = rom_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] exp_pc;
    rst_n = 1'b1;
    ifa.inst_ready = 1'b1; ifa.redirect_valid = 1'b0; ifa.redirect_pc = '0;
    ifb.inst_ready = 1'b1; ifb.redirect_valid = 1'b0; ifb.redirect_pc = '0;
    #2 rst_n = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_valid", 32'(ifa.inst_valid), 32'd0);
    check("rst_en",    32'(ifa.imem_en),    32'd0);
    check("rst_data",  ifa.inst_data,       32'd0);
    check("rst_pc",    ifa.inst_pc,         32'd0);

    // Release: issue immediately, valid after the 2nd edge
    @(negedge clk); rst_n = 1'b1; #1;
    check("start_en",    32'(ifa.imem_en),    32'd1);
    check("start_addr",  ifa.imem_addr,       32'h0);
    check("start_valid", 32'(ifa.inst_valid), 32'd0);
    @(negedge clk); #1;
    check("edge1_addr",  ifa.imem_addr,       32'h4);
    check("edge1_valid", 32'(ifa.inst_valid), 32'd0);
    for (int k = 2; k <= 7; k++) begin
      @(negedge clk); #1;
      check("stream_valid", 32'(ifa.inst_valid), 32'd1);
      check("stream_pc",    ifa.inst_pc,         32'(4 * (k - 2)));
      check("stream_data",  ifa.inst_data,       32'(4 * (k - 2)));
      check("stream_addr",  ifa.imem_addr,       32'(4 * k));
      check("wrap_pc",      ifb.inst_pc,         32'((4 * (k - 2)) % 16));
    end

    // Backpressure: head 0x18 held, issue stops at count+inflight=2
    @(negedge clk); ifa.inst_ready = 1'b0; #1;
    check("bp_pc", ifa.inst_pc, 32'h18);
    check("bp_en", 32'(ifa.imem_en), 32'd0);
    repeat (4) begin
      @(negedge clk); #1;
      check("bp_hold_pc", ifa.inst_pc, 32'h18);
      check("bp_hold_en", 32'(ifa.imem_en), 32'd0);
    end
    @(negedge clk); ifa.inst_ready = 1'b1; #1;
    check("bp_rel_pc",   ifa.inst_pc,   32'h18);
    check("bp_rel_addr", ifa.imem_addr, 32'h20);
    exp_pc = 32'h1C;
    repeat (4) begin
      @(negedge clk); #1;
      check("bp_cont_pc",   ifa.inst_pc,   exp_pc);
      check("bp_cont_data", ifa.inst_data, exp_pc);
      exp_pc += 32'd4;
    end

    // Single redirect to 0x103 (low bits dropped)
    @(negedge clk); ifa.redirect_valid = 1'b1; ifa.redirect_pc = 32'h103; #1;
    check("redir_en", 32'(ifa.imem_en), 32'd0);
    @(negedge clk); ifa.redirect_valid = 1'b0; #1;
    check("redir_flush", 32'(ifa.inst_valid), 32'd0);
    check("redir_en2",   32'(ifa.imem_en),    32'd1);
    check("redir_addr",  ifa.imem_addr,       32'h100);
    @(negedge clk); #1;
    check("redir_gap",   32'(ifa.inst_valid), 32'd0);
    @(negedge clk); #1;
    check("redir_pc",    ifa.inst_pc,   32'h100);
    check("redir_data",  ifa.inst_data, 32'h100);
    @(negedge clk); #1;
    check("redir_pc2",   ifa.inst_pc,   32'h104);

    // Back-to-back redirects: last one wins
    @(negedge clk); ifa.redirect_valid = 1'b1; ifa.redirect_pc = 32'h200; #1;
    check("b2b_en1", 32'(ifa.imem_en), 32'd0);
    @(negedge clk); ifa.redirect_pc = 32'h301; #1;
    check("b2b_en2",    32'(ifa.imem_en),    32'd0);
    check("b2b_valid",  32'(ifa.inst_valid), 32'd0);
    @(negedge clk); ifa.redirect_valid = 1'b0; #1;
    check("b2b_addr",   ifa.imem_addr, 32'h300);
    @(negedge clk);
    @(negedge clk); #1;
    check("b2b_pc",     ifa.inst_pc,   32'h300);
    check("b2b_data",   ifa.inst_data, 32'h300);
    @(negedge clk); #1;
    check("b2b_pc2",    ifa.inst_pc,   32'h304);

`ifdef FETCH_STATS_EN
    // invalid cycles: 2 at startup, 2 after the single redirect, 3 for the pair
    check("stat_redirect", redir_a, 32'd3);
    check("stat_stall",    stall_a, 32'd7);
`endif

    // Reset pulse mid-stream
    @(negedge clk); rst_n = 1'b0; #1;
    check("mrst_valid", 32'(ifa.inst_valid), 32'd0);
    check("mrst_en",    32'(ifa.imem_en),    32'd0);
    check("mrst_pc",    ifa.inst_pc,         32'd0);
    @(negedge clk); rst_n = 1'b1; #1;
    check("mrst_en2",   32'(ifa.imem_en),    32'd1);
    check("mrst_addr",  ifa.imem_addr,       32'h0);
    @(negedge clk); #1;
    check("mrst_stale", 32'(ifa.inst_valid), 32'd0);
    check("mrst_addr2", ifa.imem_addr,       32'h4);
    @(negedge clk); #1;
    check("mrst_valid2", 32'(ifa.inst_valid), 32'd1);
    check("mrst_pc2",    ifa.inst_pc,         32'h0);
    check("mrst_data2",  ifa.inst_data,       32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
